spi_sck_edge_framer: RTL and testbench

//   Front end of the SPI receive path. Synchronises the raw SCK, CS_N and MOSI pins into clk.

---
 rtl/spi_sck_edge_framer.sv | 132 +++++++++++++
 tb/tb_spi_sck_edge_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sck_edge_framer.sv
// SPI receive front end: pin synchronisers, sample-edge and CS_N edge strobes,
// bit counting, word boundaries and framing-error detection.
module spi_sck_edge_framer #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  localparam int CW         = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck_i,
  input  logic          cs_n_i,
  input  logic          mosi_i,
  output logic          mosi_o,
  output logic          sck_sample_edge,
  output logic          cs_n_falling_edge,
  output logic          cs_n_rising_edge,
  output logic          word_valid,
  output logic [CW-1:0] bit_cnt,
  output logic          frame_err,
  output logic          busy
);

  localparam logic SCK_IDLE = (CPOL != 0);
  localparam logic SAMP_RISE = (CPOL == CPHA);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic sck_h, cs_h, mosi_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s  <= {SYNC_STAGES{SCK_IDLE}};
      cs_s   <= {SYNC_STAGES{1'b1}};
      mosi_s <= '0;
      sck_h  <= SCK_IDLE;
      cs_h   <= 1'b1;
      mosi_h <= 1'b0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck_i};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n_i};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi_i};
      sck_h  <= sck_s[SYNC_STAGES-1];
      cs_h   <= cs_s[SYNC_STAGES-1];
      mosi_h <= mosi_s[SYNC_STAGES-1];
    end
  end

  logic sck_now, cs_now;
  logic samp, cs_fall, cs_rise;

  assign sck_now = sck_s[SYNC_STAGES-1];
  assign cs_now  = cs_s[SYNC_STAGES-1];
  assign samp    = SAMP_RISE ? (sck_now & ~sck_h)
                             : (~sck_now & sck_h);
  assign cs_fall = ~cs_now & cs_h;
  assign cs_rise = cs_now & ~cs_h;

  // Strobes are registered, so mosi_o uses the history flop to stay aligned.
  assign mosi_o = mosi_h;
  assign busy   = (state == ACTIVE);

  logic          samp_d, fall_d, rise_d;
  logic          wv_d, ferr_d;
  logic [CW-1:0] cnt_d;

  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    samp_d  = 1'b0;
    fall_d  = 1'b0;
    rise_d  = 1'b0;
    wv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          fall_d  = 1'b1;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (samp) begin
          samp_d = 1'b1;
          if (bit_cnt == LAST) begin
            wv_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = bit_cnt + CW'(1);
          end
        end
        // Frame end is judged on the count after any same-cycle sample.
        if (cs_rise) begin
          rise_d  = 1'b1;
          ferr_d  = (cnt_d != '0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      sck_sample_edge   <= 1'b0;
      cs_n_falling_edge <= 1'b0;
      cs_n_rising_edge  <= 1'b0;
      word_valid        <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      state             <= state_d;
      bit_cnt           <= cnt_d;
      sck_sample_edge   <= samp_d;
      cs_n_falling_edge <= fall_d;
      cs_n_rising_edge  <= rise_d;
      word_valid        <= wv_d;
      frame_err         <= ferr_d;
    end
  end

endmodule

// File: tb/tb_spi_sck_edge_framer.sv
// Scoreboard bench for spi_sck_edge_framer: mode 0 and mode 3 instances,
// directed SPI frames with hand-computed expected events.
module tb_spi_sck_edge_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sck0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
  logic sck3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;

  logic       mo0, se0, fe0, re0, wv0, er0, bz0;
  logic       mo3, se3, fe3, re3, wv3, er3, bz3;
  logic [3:0] bc0, bc3;

  spi_sck_edge_framer #(
    .DW(16), .SYNC_STAGES(2), .CPOL(0), .CPHA(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .sck_i(sck0), .cs_n_i(cs0), .mosi_i(mosi0),
    .mosi_o(mo0), .sck_sample_edge(se0),
    .cs_n_falling_edge(fe0), .cs_n_rising_edge(re0),
    .word_valid(wv0), .bit_cnt(bc0),
    .frame_err(er0), .busy(bz0)
  );

  spi_sck_edge_framer #(
    .DW(16), .SYNC_STAGES(2), .CPOL(1), .CPHA(1)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .sck_i(sck3), .cs_n_i(cs3), .mosi_i(mosi3),
    .mosi_o(mo3), .sck_sample_edge(se3),
    .cs_n_falling_edge(fe3), .cs_n_rising_edge(re3),
    .word_valid(wv3), .bit_cnt(bc3),
    .frame_err(er3), .busy(bz3)
  );

  // kind: 0 frame start, 1 sample, 2 frame end
  typedef struct {
    int         kind;
    logic       mosi;
    logic       wv;
    logic [3:0] cnt;
    logic       ferr;
    int         icyc;
  } ev_t;

  ev_t q0[$];
  ev_t q3[$];
  logic [3:0] mc[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               n, act, exp, cyc);
    end
  endtask

  task automatic mon(input string tag, inout ev_t q[$],
                     input logic se, input logic fe, input logic re,
                     input logic wv, input logic er,
                     input logic mo, input logic [3:0] bc);
    ev_t e;
    int  k;
    k = se ? 1 : (fe ? 0 : 2);
    if (q.size() == 0) begin
      chk({tag, "_unexpected_event"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_kind"}, k, e.kind);
      chk({tag, "_bit_cnt"}, int'(bc), int'(e.cnt));
      chk({tag, "_word_valid"}, int'(wv), int'(e.wv));
      chk({tag, "_frame_err"}, int'(er), int'(e.ferr));
      if (e.kind == 1) chk({tag, "_mosi"}, int'(mo), int'(e.mosi));
      if (e.kind == 2) chk({tag, "_rise"}, int'(re), 1);
      if (e.kind == 0 && e.icyc >= 0)
        chk({tag, "_fall_latency"}, cyc - e.icyc, 3);
    end
  endtask

  always @(negedge clk)
    if (rst_n && (se0 || fe0 || re0 || wv0 || er0))
      mon("m0", q0, se0, fe0, re0, wv0, er0, mo0, bc0);

  always @(negedge clk)
    if (rst_n && (se3 || fe3 || re3 || wv3 || er3))
      mon("m3", q3, se3, fe3, re3, wv3, er3, mo3, bc3);

  task automatic push(input int d, input ev_t e);
    if (d == 1) q3.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic cs_fall(input int d);
    ev_t e;
    e = '{0, 1'b0, 1'b0, 4'd0, 1'b0, cyc};
    mc[d] = 4'd0;
    push(d, e);
    if (d == 1) cs3 = 1'b0;
    else cs0 = 1'b0;
    #40;
  endtask

  task automatic cs_rise(input int d);
    ev_t e;
    e = '{2, 1'b0, 1'b0, mc[d], (mc[d] != 4'd0), -1};
    push(d, e);
    if (d == 1) cs3 = 1'b1;
    else cs0 = 1'b1;
    #80;
  endtask

  task automatic send_bit(input int d, input logic b);
    ev_t        e;
    logic [3:0] nc;
    nc = (mc[d] == 4'd15) ? 4'd0 : mc[d] + 4'd1;
    e = '{1, b, (mc[d] == 4'd15), nc, 1'b0, -1};
    mc[d] = nc;
    push(d, e);
    if (d == 1) begin
      sck3 = 1'b0;
      mosi3 = b;
      #40;
      sck3 = 1'b1;
      #40;
    end else begin
      mosi0 = b;
      #40;
      sck0 = 1'b1;
      #40;
      sck0 = 1'b0;
    end
  endtask

  task automatic send_word(input int d, input logic [15:0] w, input int n);
    logic [15:0] v;
    v = w;
    for (int i = 0; i < n; i++) send_bit(d, v[15-i]);
  endtask

  initial begin
    logic [47:0] three;
    three = {16'h1234, 16'hFFFF, 16'h0001};
    mc[0] = 4'd0;
    mc[1] = 4'd0;

    #1;
    chk("reset_outputs",
        int'({mo0, se0, fe0, re0, wv0, er0, bz0, bc0}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #40;

    // SCK activity with CS high must be ignored
    for (int i = 0; i < 8; i++) begin
      sck0 = 1'b1;
      #40;
      sck0 = 1'b0;
      #40;
    end
    chk("idle_bit_cnt", int'(bc0), 0);
    chk("idle_busy", int'(bz0), 0);

    // mode 0, one full word
    cs_fall(0);
    chk("busy_active", int'(bz0), 1);
    send_word(0, 16'hA5C3, 16);
    cs_rise(0);
    chk("busy_after_frame", int'(bz0), 0);

    // mode 3, same word
    cs_fall(1);
    send_word(1, 16'hA5C3, 16);
    cs_rise(1);

    // short frame: framing error, count holds
    cs_fall(0);
    send_word(0, 16'hB800, 5);
    cs_rise(0);
    chk("short_bit_cnt_holds", int'(bc0), 5);

    // three-word frame
    cs_fall(0);
    for (int i = 0; i < 48; i++) send_bit(0, three[47-i]);
    cs_rise(0);

    // reset mid-word, release with CS low
    cs_fall(0);
    send_word(0, 16'h5A00, 7);
    chk("midword_bit_cnt", int'(bc0), 7);
    rst_n = 1'b0;
    #1;
    chk("midword_reset_outputs",
        int'({mo0, se0, fe0, re0, wv0, er0, bz0, bc0}), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    begin
      ev_t e;
      e = '{0, 1'b0, 1'b0, 4'd0, 1'b0, cyc};
      q0.push_back(e);
    end
    mc[0] = 4'd0;
    rst_n = 1'b1;
    #80;
    chk("restart_bit_cnt", int'(bc0), 0);
    send_word(0, 16'hC000, 2);
    cs_rise(0);

    #200;
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
